// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one logical-left barrel shifter among NUM_REQ requesters.
// Result lands in a one-entry output register one edge after acceptance; full register with out_ready low stalls all requesters.

module barrel_shl #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SW-1:0]    i_shift,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] w_stage [SW+1];

  assign w_stage[0] = i_data;

  // Stage k shifts by 2^k when its amount bit is set.
  for (genvar k = 0; k < SW; k++) begin : g_stage
    assign w_stage[k+1] = i_shift[k] ? (w_stage[k] << (2**k)) : w_stage[k];
  end

  assign o_data = w_stage[SW];
endmodule

module shifter_arbiter #(
  parameter  int BIT_WIDTH  = 32,
  parameter  int NUM_REQ    = 4,
  localparam int LOG2_WIDTH = $clog2(BIT_WIDTH),
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*LOG2_WIDTH-1:0] req_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_WIDTH-1:0]          out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [15:0]                   grant_count
);
  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_vld;
  logic [BIT_WIDTH-1:0]  r_data;
  logic [ID_W-1:0]       r_id;
  logic [15:0]           r_cnt;

  logic                  w_can_accept;
  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic [ID_W:0]         w_sum;
  logic                  w_xfer;
  logic [BIT_WIDTH-1:0]  w_opnd;
  logic [LOG2_WIDTH-1:0] w_amt;
  logic [BIT_WIDTH-1:0]  w_shifted;

  assign w_can_accept = !r_vld || out_ready;

  // Search from the pointer, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[ID_W-1:0];
      end
    end
  end

  assign w_xfer = w_found && w_can_accept;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_xfer && !rst && w_win == ID_W'(i)) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    w_opnd = '0;
    w_amt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_opnd = req_data[i*BIT_WIDTH +: BIT_WIDTH];
        w_amt  = req_shift[i*LOG2_WIDTH +: LOG2_WIDTH];
      end
    end
  end

  barrel_shl #(.WIDTH(BIT_WIDTH)) u_shl (
    .i_data  (w_opnd),
    .i_shift (w_amt),
    .o_data  (w_shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_vld    <= 1'b0;
      r_data   <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
    end else if (w_xfer) begin
      r_vld    <= 1'b1;
      r_data   <= w_shifted;
      r_id     <= w_win;
      r_rr_ptr <= (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + ID_W'(1);
      r_cnt    <= r_cnt + 16'd1;
    end else if (out_ready) begin
      r_vld    <= 1'b0;
    end
  end

  assign out_valid   = r_vld;
  assign out_data    = r_data;
  assign out_id      = r_id;
  assign grant_count = r_cnt;
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed vector table, hand sequences and a random run checked against a reference model.
module tb_shifter_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int LW = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic [N*LW-1:0] req_shift;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [1:0]      out_id;
  logic [15:0]     grant_count;

  int checks;
  int failures;

  bit          m_vld;
  logic [31:0] m_data;
  int          m_id, m_ptr, m_cnt;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] data;
    logic [4:0]  sh;
    logic [3:0]  rdy;
    logic [31:0] exp;
    int          id;
  } vec_t;

  vec_t tbl[5];

  shifter_arbiter #(.BIT_WIDTH(W), .NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_shift   (req_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .grant_count (grant_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One cycle: drive, check combinational ready, clock, advance model, check registered outputs.
  task automatic step(input logic [3:0] v, input logic [N*W-1:0] d, input logic [N*LW-1:0] s,
                      input logic ordy, output bit xfer);
    int  win;
    bit  can;
    logic [3:0] exp_rdy;
    req_valid = v; req_data = d; req_shift = s; out_ready = ordy;
    #1;
    can = !m_vld || ordy;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    exp_rdy = (can && win >= 0) ? 4'(1 << win) : 4'b0000;
    chk("req_ready", req_ready, exp_rdy);
    @(posedge clk); #1;
    xfer = can && win >= 0;
    if (xfer) begin
      m_vld  = 1'b1;
      m_data = d[win*W +: W] << s[win*LW +: LW];
      m_id   = win;
      m_ptr  = (win + 1) % N;
      m_cnt  = (m_cnt + 1) % 65536;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    chk("out_valid", out_valid, m_vld);
    chk("grant_count", grant_count, m_cnt);
    if (m_vld) begin
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  function automatic logic [N*LW-1:0] rand_shift();
    logic [N*LW-1:0] s;
    for (int i = 0; i < N; i++) s[i*LW +: LW] = 5'($urandom_range(0, 31));
    return s;
  endfunction

  initial begin
    logic [N*W-1:0]  d;
    logic [N*LW-1:0] s;
    logic [31:0]     held;
    bit              x;
    int              n;

    checks = 0; failures = 0;
    model_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = '0; req_shift = '0; out_ready = 1'b1;

    tbl[0] = '{4'b0001, 32'hDEADBEEF, 5'd0,  4'b0001, 32'hDEADBEEF, 0};
    tbl[1] = '{4'b0010, 32'h00000001, 5'd31, 4'b0010, 32'h80000000, 1};
    tbl[2] = '{4'b1000, 32'hF000000F, 5'd4,  4'b1000, 32'h000000F0, 3};
    tbl[3] = '{4'b1010, 32'h12345678, 5'd16, 4'b0010, 32'h56780000, 1};
    tbl[4] = '{4'b1001, 32'hAAAA5555, 5'd1,  4'b1000, 32'h5554AAAA, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_id", out_id, 2'd0);
    chk("rst_grant_count", grant_count, 16'h0);
    req_valid = '0;
    rst = 1'b0;

    // Single request from requester 2.
    d = rand_data(); s = rand_shift();
    d[2*W +: W] = 32'h000000FF; s[2*LW +: LW] = 5'd8;
    req_valid = 4'b0100; req_data = d; req_shift = s; #1;
    chk("first_req_ready", req_ready, 4'b0100);
    step(4'b0100, d, s, 1'b1, x);
    chk("first_out_valid", out_valid, 1'b1);
    chk("first_out_data", out_data, 32'h0000FF00);
    chk("first_out_id", out_id, 2'd2);
    chk("first_grant_count", grant_count, 16'd1);

    for (int r = 0; r < 5; r++) begin
      d = rand_data(); s = rand_shift();
      d[tbl[r].id*W +: W] = tbl[r].data;
      s[tbl[r].id*LW +: LW] = tbl[r].sh;
      req_valid = tbl[r].v; req_data = d; req_shift = s; out_ready = 1'b1; #1;
      chk("tbl_req_ready", req_ready, tbl[r].rdy);
      step(tbl[r].v, d, s, 1'b1, x);
      chk("tbl_out_data", out_data, tbl[r].exp);
      chk("tbl_out_id", out_id, tbl[r].id);
    end

    // Round robin with all requesters busy.
    for (int k = 0; k < 6; k++) begin
      step(4'hF, rand_data(), rand_shift(), 1'b1, x);
      chk("rr_out_valid", out_valid, 1'b1);
      chk("rr_out_id", out_id, k % 4);
    end

    // Backpressure: accept requester 1, then stall with 0 and 3 pending.
    step(4'b0010, rand_data(), rand_shift(), 1'b1, x);
    chk("bp_out_id", out_id, 2'd1);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      step(4'b1001, rand_data(), rand_shift(), 1'b0, x);
      chk("bp_hold_ready", req_ready, 4'b0000);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_id", out_id, 2'd1);
    end
    step(4'b1001, rand_data(), rand_shift(), 1'b1, x);
    chk("bp_next_id3", out_id, 2'd3);
    step(4'b1001, rand_data(), rand_shift(), 1'b1, x);
    chk("bp_next_id0", out_id, 2'd0);

    // Asynchronous reset between edges while a result is held.
    step(4'b0000, rand_data(), rand_shift(), 1'b0, x);
    #3;
    req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_grant_count", grant_count, 16'h0);
    chk("arst_rr_ptr", dut.r_rr_ptr, 2'd0);
    chk("arst_req_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(4'hF, rand_data(), rand_shift(), 1'b1, x);
    chk("arst_first_id", out_id, 2'd0);

    // Counter wrap over 65536 random transfers.
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    n = 0;
    while (n < 65536) begin
      step(4'($urandom_range(1, 15)), rand_data(), rand_shift(),
           ($urandom_range(0, 31) != 0), x);
      if (x) begin
        n++;
        if (n == 65535) chk("wrap_pre", grant_count, 16'hFFFF);
      end
    end
    chk("wrap_zero", grant_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
